// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns the board-level asynchronous reset into NUM_OUTS staged, synchronously
//   released active-low resets. After the release of `reset` is synchronized,
//   all outputs are held low for HOLD_CYCLES edges. The outputs are then
//   released one at a time, lowest bit first, with GAP_CYCLES edges between
//   releases. A software request made while running re-runs the hold/release
//   sequence. When that re-run completes, the block acknowledges it with a
//   one-cycle pulse.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous active-low reset
//   sw_rst_req  software reset request (synchronous to clk)
//   rst_out_n   staged active-low resets, bit 0 released first
//   ready       all rst_out_n bits released
//   sw_rst_ack  one-cycle pulse when a software-initiated sequence completes
//
// Build option
//   RST_SEQ_SW_FILTER_EN : when defined, a request must be sampled high on 3
//   consecutive edges in RUN to be recognized; otherwise a single rising edge
//   in RUN is enough.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_OUTS    = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_rst_req,
  output logic [NUM_OUTS-1:0] rst_out_n,
  output logic                ready,
  output logic                sw_rst_ack
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
  logic [NUM_OUTS-1:0]      rst_q, rst_d;
  logic                     ready_q, ready_d;
  logic                     ack_q, ack_d;
  logic                     sw_flag_q, sw_flag_d;   // current sequence was software-initiated
  logic                     sw_hit;                 // request recognized this edge
  logic                     done;                   // last output released this edge
  logic [NUM_OUTS-1:0]      rel_next;

  // ---------------------------------------------------------------------------
  // Software request recognition
  // ---------------------------------------------------------------------------
`ifdef RST_SEQ_SW_FILTER_EN
  logic [1:0] filt_cnt_q, filt_cnt_d;
  logic       armed_q, armed_d;

  always_comb begin
    sw_hit     = (state_q == ST_RUN) && sw_rst_req && armed_q && (filt_cnt_q == 2'd2);
    filt_cnt_d = 2'd0;
    if ((state_q == ST_RUN) && sw_rst_req && armed_q && !sw_hit)
      filt_cnt_d = filt_cnt_q + 2'd1;
    // A held request must drop to 0 before it can be recognized again.
    armed_d = armed_q;
    if (!sw_rst_req)  armed_d = 1'b1;
    else if (sw_hit)  armed_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_cnt_q <= 2'd0;
      armed_q    <= 1'b1;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      armed_q    <= armed_d;
    end
  end
`else
  logic req_prev_q, req_prev_d;

  // History resets to 0: a request already high out of reset is never an edge
  // once RUN is reached, because the history has long since captured the 1.
  always_comb begin
    req_prev_d = sw_rst_req;
    sw_hit     = (state_q == ST_RUN) && sw_rst_req && !req_prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) req_prev_q <= 1'b0;
    else        req_prev_q <= req_prev_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rst_d      = rst_q;
    ready_d    = ready_q;
    ack_d      = 1'b0;
    sw_flag_d  = sw_flag_q;
    done       = 1'b0;
    rel_next   = (rst_q << 1) | NUM_OUTS'(1);

    case (state_q)
      ST_SYNC: begin
        // Move on at the same edge the last stage captures the 1, so the hold
        // window begins exactly when the synchronized release is visible.
        if (sync_q[SYNC_STAGES-2]) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          rst_d     = NUM_OUTS'(1);
          gap_cnt_d = '0;
          if (NUM_OUTS == 1) done    = 1'b1;
          else               state_d = ST_RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          rst_d     = rel_next;
          gap_cnt_d = '0;
          if (&rel_next) done = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_RUN: begin
        if (sw_hit) begin
          rst_d      = '0;
          ready_d    = 1'b0;
          sw_flag_d  = 1'b1;
          hold_cnt_d = '0;
          state_d    = ST_HOLD;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (done) begin
      state_d   = ST_RUN;
      ready_d   = 1'b1;
      ack_d     = sw_flag_q;
      sw_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SYNC;
      sync_q     <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rst_q      <= '0;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
      sw_flag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      sw_flag_q  <= sw_flag_d;
    end
  end

  assign rst_out_n  = rst_q;
  assign ready      = ready_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       sw_rst_req;
  logic [3:0] rst_out_n;
  logic       ready;
  logic       sw_rst_ack;

  int checks  = 0;
  int errors  = 0;
  int edge_cnt = 0;
  int ack_cnt  = 0;

  reset_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(16), .NUM_OUTS(4), .GAP_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_rst_req (sw_rst_req),
    .rst_out_n  (rst_out_n),
    .ready      (ready),
    .sw_rst_ack (sw_rst_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         e;     // edge number after reset release
    logic       req;   // sw_rst_req sampled at that edge
    logic [3:0] out;
    logic       rdy;
    logic       ack;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int e, logic req, logic [3:0] out, logic rdy, logic ack);
    vec_t v;
    v.e = e; v.req = req; v.out = out; v.rdy = rdy; v.ack = ack;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", nm, edge_cnt, got, exp);
    end
  endtask

  task automatic expect_out(string nm, logic [3:0] out, logic rdy, logic ack);
    chk({nm, " rst_out_n"}, {4'h0, rst_out_n}, {4'h0, out});
    chk({nm, " ready"}, {7'h0, ready}, {7'h0, rdy});
    chk({nm, " ack"}, {7'h0, sw_rst_ack}, {7'h0, ack});
  endtask

  // One clock edge, sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
    if (sw_rst_ack) ack_cnt++;
  endtask

  task automatic go(int e);
    while (edge_cnt < e) step();
  endtask

  // Assert reset asynchronously, hold 3 cycles, release between edges.
  task automatic do_reset();
    reset      = 1'b0;
    sw_rst_req = 1'b0;
    #1;
    expect_out("async assert", 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    expect_out("held in reset", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    reset      = 1'b0;
    sw_rst_req = 1'b0;

    // Power-on, a request pulse outside RUN at edge 20, then a software
    // request recognized at edge 41 (release 57..69, ack after edge 69).
    add( 1, 0, 4'b0000, 0, 0);
    add( 2, 0, 4'b0000, 0, 0);
    add(17, 0, 4'b0000, 0, 0);
    add(18, 0, 4'b0001, 0, 0);
    add(20, 1, 4'b0001, 0, 0);
    add(21, 0, 4'b0001, 0, 0);
    add(22, 0, 4'b0011, 0, 0);
    add(25, 0, 4'b0011, 0, 0);
    add(26, 0, 4'b0111, 0, 0);
    add(29, 0, 4'b0111, 0, 0);
    add(30, 0, 4'b1111, 1, 0);
    add(31, 0, 4'b1111, 1, 0);
    add(40, 0, 4'b1111, 1, 0);
    add(41, 1, 4'b0000, 0, 0);
    add(42, 0, 4'b0000, 0, 0);
    add(56, 0, 4'b0000, 0, 0);
    add(57, 0, 4'b0001, 0, 0);
    add(61, 0, 4'b0011, 0, 0);
    add(65, 0, 4'b0111, 0, 0);
    add(68, 0, 4'b0111, 0, 0);
    add(69, 0, 4'b1111, 1, 1);
    add(70, 0, 4'b1111, 1, 0);

    do_reset();
    foreach (tbl[i]) begin
      go(tbl[i].e - 1);
      sw_rst_req = tbl[i].req;
      step();
      expect_out($sformatf("vec%0d", i), tbl[i].out, tbl[i].rdy, tbl[i].ack);
      sw_rst_req = 1'b0;
    end
    chk("ack count after sw seq", 8'(ack_cnt), 8'd1);

    // Async reset between edges 23 and 24 (in RELEASE), then full rerun.
    do_reset();
    go(23);
    reset = 1'b0;
    #2;
    expect_out("mid-release async", 4'h0, 1'b0, 1'b0);
    do_reset();
    go(17); expect_out("rerun e17", 4'b0000, 1'b0, 1'b0);
    go(18); expect_out("rerun e18", 4'b0001, 1'b0, 1'b0);
    go(30); expect_out("rerun e30", 4'b1111, 1'b1, 1'b0);

    // Async reset during a software-initiated sequence: no ack afterwards.
    go(31);
    sw_rst_req = 1'b1;
    step();
    expect_out("swrst e32", 4'b0000, 1'b0, 1'b0);
    sw_rst_req = 1'b0;
    go(40);
    reset = 1'b0;
    #2;
    expect_out("mid-swrst async", 4'h0, 1'b0, 1'b0);
    do_reset();
    go(30); expect_out("after swrst abort e30", 4'b1111, 1'b1, 1'b0);
    go(32);
    chk("no ack for aborted sw seq", 8'(ack_cnt), 8'd1);

    // Request held high through completion: one sequence, one ack.
    sw_rst_req = 1'b1;
    step();
    expect_out("held req e33", 4'b0000, 1'b0, 1'b0);
    go(60); expect_out("held req e60", 4'b0111, 1'b0, 1'b0);
    go(61); expect_out("held req e61", 4'b1111, 1'b1, 1'b1);
    go(75); expect_out("held req e75", 4'b1111, 1'b1, 1'b0);
    chk("held req ack count", 8'(ack_cnt), 8'd2);
    sw_rst_req = 1'b0;
    step();
    sw_rst_req = 1'b1;
    step();
    expect_out("re-raise e77", 4'b0000, 1'b0, 1'b0);
    go(93); expect_out("re-raise e93", 4'b0001, 1'b0, 1'b0);
    go(105); expect_out("re-raise e105", 4'b1111, 1'b1, 1'b1);
    sw_rst_req = 1'b0;
    go(106);
    chk("re-raise ack count", 8'(ack_cnt), 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
